// File: rtl/divider_unit_pkg.sv
// divider_unit_pkg: shared operation encodings and helpers for the divider unit
package divider_unit_pkg;

    localparam int DIV_XLEN     = 32;
    localparam int DIV_OP_WIDTH = 3;

    // Encodings follow the RV32M funct3 values so the decoder can pass funct3 through
    typedef enum logic [DIV_OP_WIDTH-1:0] {
        DIV_OP_DIV  = 3'b100,
        DIV_OP_DIVU = 3'b101,
        DIV_OP_REM  = 3'b110,
        DIV_OP_REMU = 3'b111
    } div_op_e;

    function automatic logic [DIV_XLEN-1:0] neg_if(input logic [DIV_XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/divider_unit_div_iter_step.sv
// divider_unit_div_iter_step: one restoring-division iteration (shift, compare, subtract)
module divider_unit_div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] dsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o
);

    logic [XLEN-1:0] shifted;
    logic            ge;

    // Partial remainder never reaches the MSB before the final shift, so XLEN bits suffice
    always_comb begin
        shifted = {rem_i[XLEN-2:0], dvd_i[XLEN-1]};
        ge      = shifted >= dsr_i;
        rem_o   = ge ? shifted - dsr_i : shifted;
        dvd_o   = {dvd_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/divider_unit.sv
// divider_unit: multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    div_valid,
    input  logic [DIV_OP_WIDTH-1:0] DIVop,
    input  logic [XLEN-1:0]         dividend,
    input  logic [XLEN-1:0]         divisor,
    output logic                    div_ready,
    output logic                    div_busy,
    output logic [XLEN-1:0]         div_result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q;
    logic [XLEN-1:0]  dvd_q, dsr_q, rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q, rem_sel_q;

    logic             accept, is_signed, is_rem, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0]  a_mag, b_mag, special_res, rem_d, dvd_d, fix_quo, fix_rem;

    divider_unit_div_iter_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (rem_d),
        .dvd_o (dvd_d)
    );

    // Decode the request; any op other than DIV/REM/REMU behaves as DIVU
    always_comb begin
        accept      = (state_q == IDLE) && div_valid;
        is_signed   = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
        is_rem      = (DIVop == DIV_OP_REM) || (DIVop == DIV_OP_REMU);
        a_neg       = is_signed && dividend[XLEN-1];
        b_neg       = is_signed && divisor[XLEN-1];
        a_mag       = neg_if(dividend, a_neg);
        b_mag       = neg_if(divisor, b_neg);
        div_zero    = divisor == '0;
        ovf         = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
        special_res = div_zero ? (is_rem ? dividend : '1) : (is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});
        fix_quo     = neg_if(dvd_d, neg_quo_q);
        fix_rem     = neg_if(rem_d, neg_rem_q);
    end

    assign div_busy = (state_q != IDLE) || accept;

    // Control FSM: latch operands on accept, iterate XLEN times, then pulse div_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            div_ready  <= 1'b0;
            div_result <= '0;
        end else begin
            div_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_valid) begin
                        dvd_q     <= a_mag;
                        dsr_q     <= b_mag;
                        rem_q     <= '0;
                        cnt_q     <= CNT_W'(XLEN);
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        rem_sel_q <= is_rem;
                        if (div_zero || ovf) begin
                            div_result <= special_res;
                            div_ready  <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        div_result <= rem_sel_q ? fix_rem : fix_quo;
                        div_ready  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed-vector self-checking bench for divider_unit
module tb_divider_unit;
    import divider_unit_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    div_valid = 1'b0;
    logic [DIV_OP_WIDTH-1:0] DIVop = '0;
    logic [31:0]             dividend = '0;
    logic [31:0]             divisor = '0;
    logic                    div_ready;
    logic                    div_busy;
    logic [31:0]             div_result;

    int checks = 0;
    int errors = 0;

    divider_unit dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .DIVop      (DIVop),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ready  (div_ready),
        .div_busy   (div_busy),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit scramble);
        int cyc = 0;
        DIVop     = op;
        dividend  = a;
        divisor   = b;
        div_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2 && exp_lat > 2) check({tag, " busy_mid"}, 32'(div_busy), 32'd1);
            if (scramble && cyc == 3) begin
                dividend = ~a;
                divisor  = 32'd3;
                DIVop    = DIV_OP_REM;
            end
        end while (!div_ready && cyc < 60);
        div_valid = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, div_result, exp_res);
        check({tag, " busy_at_ready"}, 32'(div_busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " ready_width"}, 32'(div_ready), 32'd0);
        check({tag, " busy_idle"}, 32'(div_busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(div_ready), 32'd0);
        check("reset busy", 32'(div_busy), 32'd0);
        check("reset result", div_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("div 100/7",        DIV_OP_DIV,  32'd100,        32'd7,          32'd14,         33, 1'b0);
        run_op("rem 100/7",        DIV_OP_REM,  32'd100,        32'd7,          32'd2,          33, 1'b0);
        run_op("div -100/7",       DIV_OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   33, 1'b0);
        run_op("rem -100/7",       DIV_OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33, 1'b0);
        run_op("div 100/-7",       DIV_OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33, 1'b0);
        run_op("rem 100/-7",       DIV_OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          33, 1'b0);
        run_op("divu max/1",       DIV_OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, 1'b0);
        run_op("divu max/big",     DIV_OP_DIVU, 32'hFFFFFFFF,   32'h80000001,   32'd1,          33, 1'b0);
        run_op("remu max/big",     DIV_OP_REMU, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE,   33, 1'b0);
        run_op("div min/2",        DIV_OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33, 1'b0);
        run_op("div 0/5",          DIV_OP_DIV,  32'd0,          32'd5,          32'd0,          33, 1'b0);
        run_op("unknown op",       3'b000,      32'hFFFFFFF0,   32'd2,          32'h7FFFFFF8,   33, 1'b0);
        run_op("div 5/0",          DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1,  1'b0);
        run_op("remu 0x1234/0",    DIV_OP_REMU, 32'h1234,       32'd0,          32'h1234,       1,  1'b0);
        run_op("div overflow",     DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  1'b0);
        run_op("rem overflow",     DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  1'b0);
        run_op("divu scrambled",   DIV_OP_DIVU, 32'd1000,       32'd10,         32'd100,        33, 1'b1);
        run_op("remu 17/5",        DIV_OP_REMU, 32'd17,         32'd5,          32'd2,          33, 1'b0);

        DIVop     = DIV_OP_DIV;
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        check("mid-op busy before reset", 32'(div_busy), 32'd1);
        rst       = 1'b1;
        div_valid = 1'b0;
        #1;
        check("reset mid-op busy", 32'(div_busy), 32'd0);
        check("reset mid-op result", div_result, 32'd0);
        check("reset mid-op ready", 32'(div_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset held ready", 32'(div_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("divu 9/3 after reset", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Multicycle radix-2 restoring divider executing RV32M DIV/DIVU/REM/REMU.
- Responder side of the divide-op interface: the decode stage supplies DIVop plus a qualified div_valid; this block computes and returns the result with a ready pulse.
- Sits in the execute datapath beside the multiplier; the control FSM stalls on it.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is log2(XLEN)+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- div_valid  input  1  request, already qualified by decode (M-extension + div funct3).
- DIVop  input  `DIV_OP_WIDTH  operation select: DIV_OP_DIV / DIVU / REM / REMU.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- div_ready  output  1  one-cycle pulse; result is valid in the same cycle.
- div_busy  output  1  high from request accept until div_ready, inclusive.
- div_result  output  XLEN  registered result; held until the next accept.

Behaviour:
- Reset (async): state=IDLE, div_ready=0, div_busy=0, div_result=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE with div_valid=1 (accept):
  - Latch DIVop, operand magnitudes, quotient/remainder sign flags and the special-case flags.
  - Special case → DONE next cycle. Otherwise → CALC, counter=XLEN.
- CALC, one iteration per cycle:
  - rem = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd <<= 1.
  - If rem ≥ |divisor|: rem -= |divisor| and set quotient bit 0 to 1.
  - Counter decrements. At counter==1: apply sign fixup, load div_result, → DONE.
- DONE: div_ready=1 for exactly one cycle, then → IDLE.
- Latency:
  - Normal path: accept in cycle 0, CALC in cycles 1..32, div_ready in cycle 33.
  - Special path: div_ready in cycle 1.
- Signedness:
  - DIV/REM use operand magnitudes.
  - Quotient is negated iff the signs differ and the divisor is nonzero.
  - Remainder takes the sign of the dividend.
  - DIVU/REMU use raw values.
- Special cases (RISC-V spec), bypassing CALC:
  - divisor==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Handshake:
  - div_valid is held by the requester until div_ready and dropped in the cycle after div_ready.
  - div_valid is ignored in CALC and DONE.
  - Input changes after accept are ignored because operands are latched.
  - If div_valid is still high in IDLE after DONE, a new operation starts on the same operands; the requester must prevent this.
- Unknown DIVop value: treated as DIVU. No X propagates to div_result.
- div_busy = (state != IDLE) or accept-cycle combinational term. It is high in the accept cycle through DONE.
- Reset mid-operation: immediate IDLE. No div_ready is issued. div_result is forced to 0.

Decomposition:
- DIV_OP_WIDTH and the DIV_OP_* encodings stay in riscv_defines.vh, shared with the decoder.
- The state encodings for IDLE/CALC/DONE are local parameters in this module.
- Optional sub-module div_iter_step: combinational shift/compare/subtract for one iteration, to keep the FSM file small.
- The sign fixup and special-case detect stay in divider_unit.

Test Plan:
- DIV 100 / 7 → div_ready exactly 33 cycles after accept, result 14. REM with the same operands → 2.
- DIV 0xFFFFFF9C (-100) / 7 → 0xFFFFFFF2 (-14). REM → 0xFFFFFFFE (-2). DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. div_ready 1 cycle after accept.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. div_ready 1 cycle after accept.
- Reset mid-operation: assert rst in CALC cycle 10 → div_busy=0, div_result=0 immediately, no div_ready. A fresh DIVU 9/3 then returns 3.
- Back-to-back and handshake:
  - Change the operands while busy → result unaffected.
  - Drop div_valid after div_ready, reassert with REMU 17/5 → 2.
  - Every div_ready is exactly one cycle wide.
